// File: rtl/alu_arbiter_pkg.sv
// alu_pkg: shared types for the ALU arbiter.
//   alu_op_t    - opcodes understood by the external single-cycle ALU
//   arb_state_t - arbiter FSM states
//   is_legal_op - true for opcodes the ALU actually implements
//   idw_of      - requester-ID width for a given requester count (min 1)
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ADD, SUB, AND, OR, SLT: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side bus of the ALU arbiter.
//   slave  - arbiter view (takes requests, drives response and ALU operands)
//   master - environment view (requesters, response consumer, the ALU)
// Optional: ALU_ARB_ILLEGAL_OP_EN adds o_arb_RspIllegal.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32
);
  import alu_pkg::*;
  localparam int IDW = idw_of(NREQ);

  logic [NREQ-1:0]         i_arb_ReqValid;
  logic [NREQ-1:0]         o_arb_ReqReady;
  logic [NREQ-1:0][DW-1:0] i_arb_ReqSrcA;
  logic [NREQ-1:0][DW-1:0] i_arb_ReqSrcB;
  logic [NREQ-1:0][2:0]    i_arb_ReqALUControl;
  logic                    o_arb_RspValid;
  logic                    i_arb_RspReady;
  logic [IDW-1:0]          o_arb_RspId;
  logic [DW-1:0]           o_arb_RspResult;
  logic                    o_arb_RspZero;
  logic [DW-1:0]           o_arb_SrcA;
  logic [DW-1:0]           o_arb_SrcB;
  logic [2:0]              o_arb_ALUControl;
  logic [DW-1:0]           i_arb_ALUResult;
  logic                    i_arb_ALUZero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic                    o_arb_RspIllegal;

  modport slave (
    input  i_arb_ReqValid, i_arb_ReqSrcA, i_arb_ReqSrcB, i_arb_ReqALUControl,
           i_arb_RspReady, i_arb_ALUResult, i_arb_ALUZero,
    output o_arb_ReqReady, o_arb_RspValid, o_arb_RspId, o_arb_RspResult,
           o_arb_RspZero, o_arb_SrcA, o_arb_SrcB, o_arb_ALUControl, o_arb_RspIllegal
  );
  modport master (
    output i_arb_ReqValid, i_arb_ReqSrcA, i_arb_ReqSrcB, i_arb_ReqALUControl,
           i_arb_RspReady, i_arb_ALUResult, i_arb_ALUZero,
    input  o_arb_ReqReady, o_arb_RspValid, o_arb_RspId, o_arb_RspResult,
           o_arb_RspZero, o_arb_SrcA, o_arb_SrcB, o_arb_ALUControl, o_arb_RspIllegal
  );
`else
  modport slave (
    input  i_arb_ReqValid, i_arb_ReqSrcA, i_arb_ReqSrcB, i_arb_ReqALUControl,
           i_arb_RspReady, i_arb_ALUResult, i_arb_ALUZero,
    output o_arb_ReqReady, o_arb_RspValid, o_arb_RspId, o_arb_RspResult,
           o_arb_RspZero, o_arb_SrcA, o_arb_SrcB, o_arb_ALUControl
  );
  modport master (
    output i_arb_ReqValid, i_arb_ReqSrcA, i_arb_ReqSrcB, i_arb_ReqALUControl,
           i_arb_RspReady, i_arb_ALUResult, i_arb_ALUZero,
    input  o_arb_ReqReady, o_arb_RspValid, o_arb_RspId, o_arb_RspResult,
           o_arb_RspZero, o_arb_SrcA, o_arb_SrcB, o_arb_ALUControl
  );
`endif
endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick.
//   req       - request vector
//   ptr       - highest-priority index this round
//   grant     - one-hot winner (zero if no request)
//   grant_idx - winner index
//   any       - at least one request present
module rr_picker
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);
  int idx;

  // Walk ptr, ptr+1, ... with wrap; the first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between NREQ requesters.
//   i_arb_clk   - clock, rising edge
//   i_arb_reset - synchronous active-high reset
//   bus         - alu_arbiter_if.slave: per-requester valid/ready requests,
//                 one shared valid/ready response, ALU operand/result pins
// Flow: IDLE (round-robin grant, latch operands) -> EXEC (ALU evaluates,
// result registered) -> RESP (hold until consumed, advance pointer).
// Optional: define ALU_ARB_ILLEGAL_OP_EN to flag unimplemented opcodes
// on o_arb_RspIllegal.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input logic          i_arb_clk,
  input logic          i_arb_reset,
  alu_arbiter_if.slave bus
);
  localparam int IDW = idw_of(NREQ);

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  ptr, rsp_id, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [DW-1:0]   src_a, src_b, rsp_result;
  logic [2:0]      op;
  logic            rsp_zero;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (bus.i_arb_ReqValid),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  // Ready is only offered in IDLE, so valid&ready reduces to gnt_any there.
  assign bus.o_arb_ReqReady   = (state == IDLE) ? gnt : '0;
  assign bus.o_arb_RspValid   = (state == RESP);
  assign bus.o_arb_RspId      = rsp_id;
  assign bus.o_arb_RspResult  = rsp_result;
  assign bus.o_arb_RspZero    = rsp_zero;
  assign bus.o_arb_SrcA       = (state == IDLE) ? '0 : src_a;
  assign bus.o_arb_SrcB       = (state == IDLE) ? '0 : src_b;
  assign bus.o_arb_ALUControl = (state == IDLE) ? '0 : op;

  always_ff @(posedge i_arb_clk) begin
    if (i_arb_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.i_arb_RspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_arb_clk) begin
    if (i_arb_reset) begin
      ptr        <= '0;
      src_a      <= '0;
      src_b      <= '0;
      op         <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          src_a  <= bus.i_arb_ReqSrcA[gnt_idx];
          src_b  <= bus.i_arb_ReqSrcB[gnt_idx];
          op     <= bus.i_arb_ReqALUControl[gnt_idx];
          rsp_id <= gnt_idx;
        end
        EXEC: begin
          rsp_result <= bus.i_arb_ALUResult;
          rsp_zero   <= bus.i_arb_ALUZero;
        end
        RESP: if (bus.i_arb_RspReady)
          // The owner just served drops to lowest priority next round.
          ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic rsp_illegal;
  always_ff @(posedge i_arb_clk) begin
    if (i_arb_reset)         rsp_illegal <= 1'b0;
    else if (state == EXEC)  rsp_illegal <= !is_legal_op(op);
  end
  assign bus.o_arb_RspIllegal = rsp_illegal;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter (NREQ=2).
// A tiny behavioural ALU closes the loop on the ALU-side pins.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(2), .DW(32)) bus ();

  alu_arbiter #(.NREQ(2), .DW(32)) dut (
    .i_arb_clk   (clk),
    .i_arb_reset (rst),
    .bus         (bus)
  );

  // External single-cycle ALU.
  always_comb begin
    case (bus.o_arb_ALUControl)
      3'b000:  bus.i_arb_ALUResult = bus.o_arb_SrcA + bus.o_arb_SrcB;
      3'b001:  bus.i_arb_ALUResult = bus.o_arb_SrcA - bus.o_arb_SrcB;
      3'b010:  bus.i_arb_ALUResult = bus.o_arb_SrcA & bus.o_arb_SrcB;
      3'b011:  bus.i_arb_ALUResult = bus.o_arb_SrcA | bus.o_arb_SrcB;
      3'b101:  bus.i_arb_ALUResult = ($signed(bus.o_arb_SrcA) < $signed(bus.o_arb_SrcB)) ? 32'd1 : 32'd0;
      default: bus.i_arb_ALUResult = 32'd0;
    endcase
    bus.i_arb_ALUZero = (bus.i_arb_ALUResult == 32'd0);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] vld,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1);
    bus.i_arb_ReqValid         = vld;
    bus.i_arb_ReqSrcA[0]       = a0;
    bus.i_arb_ReqSrcB[0]       = b0;
    bus.i_arb_ReqALUControl[0] = op0;
    bus.i_arb_ReqSrcA[1]       = a1;
    bus.i_arb_ReqSrcB[1]       = b1;
    bus.i_arb_ReqALUControl[1] = op1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] a0, b0;
    logic [2:0]  op0;
    logic [31:0] a1, b1;
    logic [2:0]  op1;
    logic [1:0]  exp_gnt;
    logic        exp_id;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  vec_t vt[9];

  // One full transaction: grant in IDLE, no response in EXEC, response in RESP.
  task automatic run_vec(input int k, input vec_t v);
    bit got;
    set_req(v.vld, v.a0, v.b0, v.op0, v.a1, v.b1, v.op1);
    bus.i_arb_RspReady = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus.o_arb_ReqReady != 2'b00) got = 1;
      else step();
    end
    chk($sformatf("v%0d_grant", k), {30'd0, bus.o_arb_ReqReady}, {30'd0, v.exp_gnt});
    step();
    bus.i_arb_ReqValid = 2'b00;
    @(negedge clk);
    chk($sformatf("v%0d_exec_novalid", k), {31'd0, bus.o_arb_RspValid}, 32'd0);
    step();
    @(negedge clk);
    chk($sformatf("v%0d_rspvalid", k), {31'd0, bus.o_arb_RspValid}, 32'd1);
    chk($sformatf("v%0d_id", k), {31'd0, bus.o_arb_RspId}, {31'd0, v.exp_id});
    chk($sformatf("v%0d_result", k), bus.o_arb_RspResult, v.exp_res);
    chk($sformatf("v%0d_zero", k), {31'd0, bus.o_arb_RspZero}, {31'd0, v.exp_zero});
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk($sformatf("v%0d_illegal", k), {31'd0, bus.o_arb_RspIllegal}, {31'd0, v.exp_ill});
`endif
    step();
    bus.i_arb_RspReady = 1'b1;
    step();
    bus.i_arb_RspReady = 1'b0;
  endtask

  logic [31:0] ids[$];
  logic [31:0] res[$];
  logic [31:0] hold_res;

  initial begin
    // ptr sequence through the table: 0,1,0,1,1,0,0,1,0
    vt[0] = '{2'b01, 32'd5, 32'd3, 3'b000, 32'd0, 32'd0, 3'b000, 2'b01, 1'b0, 32'd8, 1'b0, 1'b0};
    vt[1] = '{2'b11, 32'd9, 32'd9, 3'b000, 32'h1234, 32'h1234, 3'b001, 2'b10, 1'b1, 32'd0, 1'b1, 1'b0};
    vt[2] = '{2'b11, 32'd2, 32'd7, 3'b101, 32'd1, 32'd1, 3'b000, 2'b01, 1'b0, 32'd1, 1'b0, 1'b0};
    vt[3] = '{2'b01, 32'hF0F0, 32'h0FF0, 3'b010, 32'd0, 32'd0, 3'b000, 2'b01, 1'b0, 32'h00F0, 1'b0, 1'b0};
    vt[4] = '{2'b10, 32'd0, 32'd0, 3'b000, 32'hF000, 32'h000F, 3'b011, 2'b10, 1'b1, 32'hF00F, 1'b0, 1'b0};
    vt[5] = '{2'b10, 32'd0, 32'd0, 3'b000, 32'd3, 32'd5, 3'b001, 2'b10, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[6] = '{2'b11, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd4, 32'd4, 3'b000, 2'b01, 1'b0, 32'd0, 1'b1, 1'b0};
    vt[7] = '{2'b10, 32'd0, 32'd0, 3'b000, 32'd9, 32'd9, 3'b110, 2'b10, 1'b1, 32'd0, 1'b1, 1'b1};
    vt[8] = '{2'b11, 32'hFFFFFFFE, 32'd1, 3'b101, 32'd7, 32'd7, 3'b100, 2'b01, 1'b0, 32'd1, 1'b0, 1'b0};

    bus.i_arb_RspReady = 1'b0;
    set_req(2'b00, 0, 0, 3'b000, 0, 0, 3'b000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_reqready", {30'd0, bus.o_arb_ReqReady}, 32'd0);
    chk("rst_rspvalid", {31'd0, bus.o_arb_RspValid}, 32'd0);
    chk("rst_rspid",    {31'd0, bus.o_arb_RspId}, 32'd0);
    chk("rst_result",   bus.o_arb_RspResult, 32'd0);
    chk("rst_zero",     {31'd0, bus.o_arb_RspZero}, 32'd0);
    chk("rst_srca",     bus.o_arb_SrcA, 32'd0);
    chk("rst_aluctl",   {29'd0, bus.o_arb_ALUControl}, 32'd0);
    step();

    for (int k = 0; k < 9; k++) run_vec(k, vt[k]);

    // Alternation: both valid, consumer always ready, 12 cycles from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(2'b11, 32'd1, 32'd1, 3'b000, 32'd10, 32'd10, 3'b000);
    bus.i_arb_RspReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.o_arb_RspValid) begin
        ids.push_back({31'd0, bus.o_arb_RspId});
        res.push_back(bus.o_arb_RspResult);
      end
    end
    step();
    set_req(2'b00, 0, 0, 3'b000, 0, 0, 3'b000);
    bus.i_arb_RspReady = 1'b0;
    chk("alt_count", ids.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ids.size()) begin
        chk($sformatf("alt_id%0d", i), ids[i], (i % 2 == 0) ? 32'd0 : 32'd1);
        chk($sformatf("alt_res%0d", i), res[i], (i % 2 == 0) ? 32'd2 : 32'd20);
      end
    end

    // Backpressure: ptr is 0 here; req0 wins, response held for 5 cycles.
    set_req(2'b11, 32'd100, 32'd23, 3'b000, 32'd50, 32'd8, 3'b001);
    @(negedge clk);
    chk("bp_grant0", {30'd0, bus.o_arb_ReqReady}, 32'd1);
    step();
    step();
    hold_res = 32'd123;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", c), {31'd0, bus.o_arb_RspValid}, 32'd1);
      chk($sformatf("bp_res%0d", c), bus.o_arb_RspResult, hold_res);
      chk($sformatf("bp_id%0d", c), {31'd0, bus.o_arb_RspId}, 32'd0);
      chk($sformatf("bp_rdy%0d", c), {30'd0, bus.o_arb_ReqReady}, 32'd0);
      step();
    end
    bus.i_arb_RspReady = 1'b1;
    step();
    bus.i_arb_RspReady = 1'b0;
    @(negedge clk);
    chk("bp_next_grant", {30'd0, bus.o_arb_ReqReady}, 32'd2);
    step();
    bus.i_arb_ReqValid = 2'b00;
    step();
    @(negedge clk);
    chk("bp_req1_res", bus.o_arb_RspResult, 32'd42);
    chk("bp_req1_id", {31'd0, bus.o_arb_RspId}, 32'd1);
    step();
    bus.i_arb_RspReady = 1'b1;
    step();
    bus.i_arb_RspReady = 1'b0;

    // Leave ptr at 1 so the reset test shows it returning to 0.
    run_vec(9, '{2'b01, 32'd6, 32'd1, 3'b000, 32'd0, 32'd0, 3'b000, 2'b01, 1'b0, 32'd7, 1'b0, 1'b0});

    // Reset pulsed during EXEC discards the in-flight op.
    set_req(2'b11, 32'd30, 32'd4, 3'b000, 32'd77, 32'd1, 3'b000);
    @(negedge clk);
    chk("rx_pre_grant", {30'd0, bus.o_arb_ReqReady}, 32'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rx_rspvalid", {31'd0, bus.o_arb_RspValid}, 32'd0);
    chk("rx_result", bus.o_arb_RspResult, 32'd0);
    chk("rx_grant", {30'd0, bus.o_arb_ReqReady}, 32'd1);
    step();
    bus.i_arb_ReqValid = 2'b00;
    @(negedge clk);
    chk("rx_exec_novalid", {31'd0, bus.o_arb_RspValid}, 32'd0);
    step();
    @(negedge clk);
    chk("rx_rsp_id", {31'd0, bus.o_arb_RspId}, 32'd0);
    chk("rx_rsp_res", bus.o_arb_RspResult, 32'd34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one single-cycle ALU between NREQ requesters, for example the execute stage and a debug or CSR unit.
- Per-requester valid/ready request channel and one shared valid/ready response channel.
- Requests are granted round-robin. Operands are latched, driven to the external ALU, and the result is registered.
- One operation is in flight at a time. The block drives the ALU's SrcA/SrcB/ALUControl inputs and samples its ALUResult/ALUZero outputs.

Parameters:
- NREQ, 2, number of requesters (2..8)
- IDW, $clog2(NREQ) (min 1), width of the requester ID
- DW, 32, operand/result width

Ports:
- i_arb_clk  input  1  clock; every register updates on the rising edge
- i_arb_reset  input  1  reset, synchronous, active-high
- i_arb_ReqValid  input  NREQ  per-requester request valid
- o_arb_ReqReady  output  NREQ  per-requester accept, one-hot or zero
- i_arb_ReqSrcA  input  NREQ*DW  packed operand A per requester
- i_arb_ReqSrcB  input  NREQ*DW  packed operand B per requester
- i_arb_ReqALUControl  input  NREQ*3  packed opcode per requester
- o_arb_RspValid  output  1  response valid
- i_arb_RspReady  input  1  response consumer ready
- o_arb_RspId  output  IDW  index of the requester that owns the response
- o_arb_RspResult  output  DW  registered ALU result
- o_arb_RspZero  output  1  registered ALU zero flag
- o_arb_SrcA  output  DW  to ALU
- o_arb_SrcB  output  DW  to ALU
- o_arb_ALUControl  output  3  to ALU
- i_arb_ALUResult  input  DW  from ALU
- i_arb_ALUZero  input  1  from ALU

Behaviour:
- Reset values: state=IDLE, rr pointer=0, o_arb_RspValid=0, o_arb_RspId=0, o_arb_RspResult=0, o_arb_RspZero=0, latched operands/opcode=0. All ALU-side outputs are 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first requester with i_arb_ReqValid=1, searching from index ptr upward with wrap-around mod NREQ.
  - o_arb_ReqReady = one-hot of the winner. It is combinational from ReqValid and ptr, and is all-zero when no request is valid or state≠IDLE.
  - On handshake (valid&ready): latch the winner's SrcA/SrcB/ALUControl and its ID, then go to EXEC.
- EXEC:
  - ALU-side outputs carry the latched values. They also hold these values in RESP and reset to 0 in IDLE.
  - Capture i_arb_ALUResult/i_arb_ALUZero into the Rsp registers, then go to RESP.
- RESP:
  - o_arb_RspValid=1. Result, Zero and Id are held stable until i_arb_RspReady=1.
  - On RspReady: ptr←(Id+1) mod NREQ, RspValid←0, go to IDLE.
- Latency: handshake in cycle T gives RspValid in cycle T+2. Best-case throughput is 1 op per 3 cycles.
- Fairness: a requester that holds valid is granted within NREQ operations.
- Requesters may change or drop ReqValid freely while not ready. Requests are not queued.
- Opcodes: 000 add, 001 sub, 010 and, 011 or, 101 slt. The codes 100/110/111 are passed through unchanged; the ALU returns 0 for them.
- Reset asserted in any state: the next state is IDLE with reset values. An in-flight response is discarded and never presented.
- RspReady sampled in IDLE or EXEC is ignored.
- NREQ=1 degenerates to the same FSM with a constant grant.

Optional Feature:
- Macro ALU_ARB_ILLEGAL_OP_EN.
- Defined:
  - Adds output o_arb_RspIllegal (1 bit), reset 0, registered in EXEC, held with the response.
  - It is 1 when the latched opcode ∉ {000,001,010,011,101}. Result and zero still come from the ALU (0/0).
- Undefined: the port is absent and opcodes are passed through with no check.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLT=3'b101.
  - arb_state_t enum: IDLE, EXEC, RESP.
  - function is_legal_op.
- Sub-module rr_picker (combinational): inputs req[NREQ] and ptr; outputs one-hot grant, grant index and any.

Test Plan:
- Single request: req0 valid, A=5, B=3, op=000 at cycle 1 → ReqReady[0]=1 in cycle 1; RspValid=1 in cycle 3 with Result=8, Id=0, Zero=0.
- Both requesters valid continuously, RspReady=1 → grants alternate 0,1,0,1. Expect 4 responses with Ids 0,1,0,1 in 12 cycles.
- SUB with A=B=0x1234 → Result=0, Zero=1. SLT with A=2, B=7 → Result=1, Zero=0.
- Backpressure: RspReady held 0 for 5 cycles in RESP → Result/Id stable, ReqReady all 0; the next grant follows the cycle RspReady=1 is sampled.
- Reset pulsed in EXEC → next cycle IDLE, RspValid=0, ptr=0; with both requesters valid, req0 is granted first.
- With ALU_ARB_ILLEGAL_OP_EN, op=3'b110 → Result=0, RspIllegal=1. Op=011 → RspIllegal=0.
